// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 exception-side definitions: ExcCode values, CP0 register
// addresses, exc_vec_i bit indices and Status/Cause bit positions.
package cp0_exc_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned EXC_VEC_W  = 7;
  localparam int unsigned EXC_CODE_W = 5;
  localparam int unsigned CP0_ADDR_W = 5;

  // Cause.ExcCode encodings
  localparam logic [EXC_CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_CODE_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_CODE_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'd12;

  // CP0 register addresses
  localparam logic [CP0_ADDR_W-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [CP0_ADDR_W-1:0] CP0_STATUS   = 5'd12;
  localparam logic [CP0_ADDR_W-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [CP0_ADDR_W-1:0] CP0_EPC      = 5'd14;

  // exc_vec_i = {eret, ades, bp, sys, ov, ri, adel}
  localparam int unsigned EV_ADEL = 0;
  localparam int unsigned EV_RI   = 1;
  localparam int unsigned EV_OV   = 2;
  localparam int unsigned EV_SYS  = 3;
  localparam int unsigned EV_BP   = 4;
  localparam int unsigned EV_ADES = 5;
  localparam int unsigned EV_ERET = 6;

  // Status / Cause bit positions
  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned IM_LO      = 8;
  localparam int unsigned IM_HI      = 15;
  localparam int unsigned IP_SW_LO   = 8;
  localparam int unsigned IP_SW_HI   = 9;

  // Address-error codes are the ones that also load BadVAddr
  function automatic logic is_addr_exc(input logic [EXC_CODE_W-1:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational exception priority encoder:
// Int > AdEL > RI > Ov > Sys > Bp > AdES > eret.
module cp0_exc_prio
  import cp0_exc_ctrl_pkg::*;
(
  input  logic                  valid_i,
  input  logic                  int_i,
  input  logic [EXC_VEC_W-1:0]  exc_vec_i,
  output logic                  hit_c,
  output logic                  is_eret_c,
  output logic [EXC_CODE_W-1:0] exc_code_c
);

  // Pick the single highest-priority event of a valid instruction
  always_comb begin
    hit_c      = 1'b0;
    is_eret_c  = 1'b0;
    exc_code_c = EXC_INT;
    if (valid_i) begin
      hit_c = 1'b1;
      if (int_i)                       exc_code_c = EXC_INT;
      else if (exc_vec_i[EV_ADEL])     exc_code_c = EXC_ADEL;
      else if (exc_vec_i[EV_RI])       exc_code_c = EXC_RI;
      else if (exc_vec_i[EV_OV])       exc_code_c = EXC_OV;
      else if (exc_vec_i[EV_SYS])      exc_code_c = EXC_SYS;
      else if (exc_vec_i[EV_BP])       exc_code_c = EXC_BP;
      else if (exc_vec_i[EV_ADES])     exc_code_c = EXC_ADES;
      else if (exc_vec_i[EV_ERET])     is_eret_c  = 1'b1;
      else                             hit_c      = 1'b0;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside MEM: decides trap/eret, drives
// flush, redirect PC and one-shot CP0 update strobes (all registered).
// Optional BadVAddr update enabled by defining CP0_EXC_BADVADDR_EN.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [EXC_VEC_W-1:0]  exc_vec_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       bad_addr_i,
  input  logic                  in_delay_slot_i,
  input  logic [XLEN-1:0]       status_i,
  input  logic [XLEN-1:0]       cause_i,
  input  logic [XLEN-1:0]       epc_i,
  input  logic                  wb_cp0_we_i,
  input  logic [CP0_ADDR_W-1:0] wb_cp0_waddr_i,
  input  logic [XLEN-1:0]       wb_cp0_wdata_i,
  output logic                  flush_o,
  output logic [XLEN-1:0]       new_pc_o,
  output logic                  epc_we_o,
  output logic [XLEN-1:0]       epc_wdata_o,
  output logic                  cause_we_o,
  output logic [EXC_CODE_W-1:0] exc_code_o,
  output logic                  bd_o,
  output logic                  exl_set_o,
  output logic                  exl_clr_o,
  output logic                  badvaddr_we_o,
  output logic [XLEN-1:0]       badvaddr_o
);

  localparam int unsigned CNT_W = 3;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [CNT_W-1:0] DRAIN_INIT =
    CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  logic [XLEN-1:0] eff_status, eff_cause, eff_epc;
  logic            int_c, hit_c, is_eret_c;
  logic [EXC_CODE_W-1:0] code_c;

  logic [1:0]            state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic                  flush_d, flush_q;
  logic [XLEN-1:0]       new_pc_d, new_pc_q;
  logic                  epc_we_d, epc_we_q;
  logic [XLEN-1:0]       epc_wdata_d, epc_wdata_q;
  logic                  cause_we_d, cause_we_q;
  logic [EXC_CODE_W-1:0] exc_code_d, exc_code_q;
  logic                  bd_d, bd_q;
  logic                  exl_set_d, exl_set_q;
  logic                  exl_clr_d, exl_clr_q;
`ifdef CP0_EXC_BADVADDR_EN
  logic                  badvaddr_we_d, badvaddr_we_q;
  logic [XLEN-1:0]       badvaddr_d, badvaddr_q;
`endif

  // WB-stage mtc0 forwarding into Status / Cause.IP[1:0] / EPC
  always_comb begin
    eff_status = status_i;
    eff_cause  = cause_i;
    eff_epc    = epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == CP0_STATUS) eff_status = wb_cp0_wdata_i;
      if (wb_cp0_waddr_i == CP0_CAUSE)
        eff_cause[IP_SW_HI:IP_SW_LO] = wb_cp0_wdata_i[IP_SW_HI:IP_SW_LO];
      if (wb_cp0_waddr_i == CP0_EPC)    eff_epc = wb_cp0_wdata_i;
    end
  end

  assign int_c = eff_status[STATUS_IE] && !eff_status[STATUS_EXL] &&
                 (|(eff_cause[IM_HI:IM_LO] & eff_status[IM_HI:IM_LO]));

  cp0_exc_prio u_prio (
    .valid_i    (valid_i),
    .int_i      (int_c),
    .exc_vec_i  (exc_vec_i),
    .hit_c      (hit_c),
    .is_eret_c  (is_eret_c),
    .exc_code_c (code_c)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = 1'b0;
    new_pc_d    = '0;
    epc_we_d    = 1'b0;
    epc_wdata_d = '0;
    cause_we_d  = 1'b0;
    exc_code_d  = '0;
    bd_d        = 1'b0;
    exl_set_d   = 1'b0;
    exl_clr_d   = 1'b0;
`ifdef CP0_EXC_BADVADDR_EN
    badvaddr_we_d = 1'b0;
    badvaddr_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (hit_c) begin
          state_d = S_FLUSH;
          flush_d = 1'b1;
          if (is_eret_c) begin
            new_pc_d  = eff_epc;
            exl_clr_d = 1'b1;
          end else begin
            new_pc_d   = EXC_VECTOR;
            cause_we_d = 1'b1;
            exc_code_d = code_c;
            exl_set_d  = 1'b1;
            if (!eff_status[STATUS_EXL]) begin
              epc_we_d    = 1'b1;
              epc_wdata_d = in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
              bd_d        = in_delay_slot_i;
            end
`ifdef CP0_EXC_BADVADDR_EN
            if (is_addr_exc(code_c)) begin
              badvaddr_we_d = 1'b1;
              badvaddr_d    = bad_addr_i;
            end
`endif
          end
        end
      end
      S_FLUSH: begin
        if (FLUSH_CYCLES > 1) begin
          state_d  = S_DRAIN;
          cnt_d    = DRAIN_INIT;
          flush_d  = 1'b1;
          new_pc_d = new_pc_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          flush_d  = 1'b1;
          new_pc_d = new_pc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      new_pc_q    <= '0;
      epc_we_q    <= 1'b0;
      epc_wdata_q <= '0;
      cause_we_q  <= 1'b0;
      exc_code_q  <= '0;
      bd_q        <= 1'b0;
      exl_set_q   <= 1'b0;
      exl_clr_q   <= 1'b0;
`ifdef CP0_EXC_BADVADDR_EN
      badvaddr_we_q <= 1'b0;
      badvaddr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      new_pc_q    <= new_pc_d;
      epc_we_q    <= epc_we_d;
      epc_wdata_q <= epc_wdata_d;
      cause_we_q  <= cause_we_d;
      exc_code_q  <= exc_code_d;
      bd_q        <= bd_d;
      exl_set_q   <= exl_set_d;
      exl_clr_q   <= exl_clr_d;
`ifdef CP0_EXC_BADVADDR_EN
      badvaddr_we_q <= badvaddr_we_d;
      badvaddr_q    <= badvaddr_d;
`endif
    end
  end

  assign flush_o     = flush_q;
  assign new_pc_o    = new_pc_q;
  assign epc_we_o    = epc_we_q;
  assign epc_wdata_o = epc_wdata_q;
  assign cause_we_o  = cause_we_q;
  assign exc_code_o  = exc_code_q;
  assign bd_o        = bd_q;
  assign exl_set_o   = exl_set_q;
  assign exl_clr_o   = exl_clr_q;

`ifdef CP0_EXC_BADVADDR_EN
  assign badvaddr_we_o = badvaddr_we_q;
  assign badvaddr_o    = badvaddr_q;
  logic unused_bits;
  assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                         eff_cause[31:16], eff_cause[7:0]};
`else
  assign badvaddr_we_o = 1'b0;
  assign badvaddr_o    = '0;
  logic unused_bits;
  assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                         eff_cause[31:16], eff_cause[7:0], bad_addr_i};
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: one default instance and one with
// FLUSH_CYCLES=3, both driven by the same MEM/CP0 stimulus.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [6:0]  exc_vec_i;
  logic [31:0] pc_i, bad_addr_i, status_i, cause_i, epc_i, wb_cp0_wdata_i;
  logic        in_delay_slot_i, wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;

  logic        flush, epc_we, cause_we, bd, exl_set, exl_clr, bav_we;
  logic [31:0] new_pc, epc_wdata, bav;
  logic [4:0]  exc_code;
  logic        flush3, epc_we3, cause_we3, bd3, exl_set3, exl_clr3, bav_we3;
  logic [31:0] new_pc3, epc_wdata3, bav3;
  logic [4:0]  exc_code3;

  int n_err = 0;
  int n_checks = 0;

  localparam logic [31:0] VEC = 32'hBFC00380;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .exc_vec_i(exc_vec_i),
    .pc_i(pc_i), .bad_addr_i(bad_addr_i), .in_delay_slot_i(in_delay_slot_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .flush_o(flush), .new_pc_o(new_pc), .epc_we_o(epc_we),
    .epc_wdata_o(epc_wdata), .cause_we_o(cause_we), .exc_code_o(exc_code),
    .bd_o(bd), .exl_set_o(exl_set), .exl_clr_o(exl_clr),
    .badvaddr_we_o(bav_we), .badvaddr_o(bav)
  );

  cp0_exc_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .exc_vec_i(exc_vec_i),
    .pc_i(pc_i), .bad_addr_i(bad_addr_i), .in_delay_slot_i(in_delay_slot_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .flush_o(flush3), .new_pc_o(new_pc3), .epc_we_o(epc_we3),
    .epc_wdata_o(epc_wdata3), .cause_we_o(cause_we3), .exc_code_o(exc_code3),
    .bd_o(bd3), .exl_set_o(exl_set3), .exl_clr_o(exl_clr3),
    .badvaddr_we_o(bav_we3), .badvaddr_o(bav3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i         = 1'b0;
    exc_vec_i       = 7'd0;
    pc_i            = 32'd0;
    bad_addr_i      = 32'd0;
    in_delay_slot_i = 1'b0;
    status_i        = 32'd0;
    cause_i         = 32'd0;
    epc_i           = 32'd0;
    wb_cp0_we_i     = 1'b0;
    wb_cp0_waddr_i  = 5'd0;
    wb_cp0_wdata_i  = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_flush",    32'(flush),    32'd0);
    chk("rst_new_pc",   new_pc,        32'd0);
    chk("rst_epc_we",   32'(epc_we),   32'd0);
    chk("rst_cause_we", 32'(cause_we), 32'd0);
    chk("rst_exl_set",  32'(exl_set),  32'd0);
    chk("rst_flush3",   32'(flush3),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: syscall, not in delay slot
    valid_i = 1'b1; exc_vec_i = 7'b0001000; pc_i = 32'h80001000;
    tick();
    idle_inputs();
    chk("sys_flush",     32'(flush),     32'd1);
    chk("sys_new_pc",    new_pc,         VEC);
    chk("sys_epc_we",    32'(epc_we),    32'd1);
    chk("sys_epc",       epc_wdata,      32'h80001000);
    chk("sys_cause_we",  32'(cause_we),  32'd1);
    chk("sys_code",      32'(exc_code),  32'd8);
    chk("sys_bd",        32'(bd),        32'd0);
    chk("sys_exl_set",   32'(exl_set),   32'd1);
    chk("sys_exl_clr",   32'(exl_clr),   32'd0);
    tick();
    chk("sys_flush_off",   32'(flush),    32'd0);
    chk("sys_epc_we_off",  32'(epc_we),   32'd0);
    chk("sys_exl_set_off", 32'(exl_set),  32'd0);

    // 2: overflow in delay slot
    valid_i = 1'b1; exc_vec_i = 7'b0000100; pc_i = 32'h80002004; in_delay_slot_i = 1'b1;
    tick();
    idle_inputs();
    chk("ov_epc",  epc_wdata,     32'h80002000);
    chk("ov_bd",   32'(bd),       32'd1);
    chk("ov_code", 32'(exc_code), 32'd12);
    tick();

    // 3a: interrupt enabled only through forwarded Status
    valid_i = 1'b1; pc_i = 32'h80005000; cause_i = 32'h00000400;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_wdata_i = 32'h0000FF01;
    tick();
    idle_inputs();
    chk("int_flush", 32'(flush),     32'd1);
    chk("int_code",  32'(exc_code),  32'd0);
    chk("int_epc",   epc_wdata,      32'h80005000);
    tick();

    // 3b: forwarded Status.IE=0 masks interrupt
    valid_i = 1'b1; pc_i = 32'h80005000; cause_i = 32'h00000400; status_i = 32'h0000FF01;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_wdata_i = 32'h0000FF00;
    tick();
    idle_inputs();
    chk("int_masked_flush",    32'(flush),    32'd0);
    chk("int_masked_cause_we", 32'(cause_we), 32'd0);

    // 3c: software IP forwarded into Cause
    valid_i = 1'b1; pc_i = 32'h80005100; status_i = 32'h0000FF01;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_wdata_i = 32'h00000200;
    tick();
    idle_inputs();
    chk("swint_flush", 32'(flush),    32'd1);
    chk("swint_code",  32'(exc_code), 32'd0);
    tick();

    // 4: eret with forwarded EPC
    valid_i = 1'b1; exc_vec_i = 7'b1000000; status_i = 32'h00000003; epc_i = 32'h80003000;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h80004000;
    tick();
    idle_inputs();
    chk("eret_flush",    32'(flush),    32'd1);
    chk("eret_new_pc",   new_pc,        32'h80004000);
    chk("eret_exl_clr",  32'(exl_clr),  32'd1);
    chk("eret_epc_we",   32'(epc_we),   32'd0);
    chk("eret_cause_we", 32'(cause_we), 32'd0);
    chk("eret_exl_set",  32'(exl_set),  32'd0);
    tick();

    // 4b: eret using CP0 EPC directly
    valid_i = 1'b1; exc_vec_i = 7'b1000000; status_i = 32'h00000002; epc_i = 32'h80003000;
    tick();
    idle_inputs();
    chk("eret2_new_pc", new_pc, 32'h80003000);
    tick();

    // 6: EXL already set, bp in delay slot
    valid_i = 1'b1; exc_vec_i = 7'b0010000; status_i = 32'h00000002;
    pc_i = 32'h80006004; in_delay_slot_i = 1'b1;
    tick();
    idle_inputs();
    chk("exl_cause_we", 32'(cause_we), 32'd1);
    chk("exl_code",     32'(exc_code), 32'd9);
    chk("exl_epc_we",   32'(epc_we),   32'd0);
    chk("exl_bd",       32'(bd),       32'd0);
    chk("exl_new_pc",   new_pc,        VEC);
    tick();

    // priority: adel beats ri and sys
    valid_i = 1'b1; exc_vec_i = 7'b0001011; pc_i = 32'h80000010; bad_addr_i = 32'h80000003;
    tick();
    idle_inputs();
    chk("prio_code", 32'(exc_code), 32'd4);
`ifdef CP0_EXC_BADVADDR_EN
    chk("adel_bav_we", 32'(bav_we), 32'd1);
    chk("adel_bav",    bav,         32'h80000003);
`else
    chk("adel_bav_we", 32'(bav_we), 32'd0);
    chk("adel_bav",    bav,         32'd0);
`endif
    tick();

    // ades alone, and eret loses to sys
    valid_i = 1'b1; exc_vec_i = 7'b0100000;
    tick();
    idle_inputs();
    chk("ades_code", 32'(exc_code), 32'd5);
    tick();
    valid_i = 1'b1; exc_vec_i = 7'b1001000;
    tick();
    idle_inputs();
    chk("eret_sys_code", 32'(exc_code), 32'd8);
    chk("eret_sys_clr",  32'(exl_clr),  32'd0);
    tick();

    // pc-4 wraps
    valid_i = 1'b1; exc_vec_i = 7'b0001000; pc_i = 32'h00000000; in_delay_slot_i = 1'b1;
    tick();
    idle_inputs();
    chk("wrap_epc", epc_wdata, 32'hFFFFFFFC);
    chk("wrap_bd",  32'(bd),   32'd1);
    tick();

    // valid_i=0 masks exceptions and interrupts
    exc_vec_i = 7'b0001000; status_i = 32'h0000FF01; cause_i = 32'h0000FF00;
    tick();
    idle_inputs();
    chk("novalid_flush", 32'(flush), 32'd0);

    // 5: FLUSH_CYCLES=3, follow-on sys discarded
    repeat (4) tick();
    valid_i = 1'b1; exc_vec_i = 7'b0000010; pc_i = 32'h80007000;
    tick();
    exc_vec_i = 7'b0001000; pc_i = 32'h80007004;
    chk("f3_c1_flush",    32'(flush3),    32'd1);
    chk("f3_c1_cause_we", 32'(cause_we3), 32'd1);
    chk("f3_c1_code",     32'(exc_code3), 32'd10);
    tick();
    chk("f3_c2_flush",    32'(flush3),    32'd1);
    chk("f3_c2_cause_we", 32'(cause_we3), 32'd0);
    chk("f3_c2_exl_set",  32'(exl_set3),  32'd0);
    chk("f3_c2_new_pc",   new_pc3,        VEC);
    tick();
    idle_inputs();
    chk("f3_c3_flush",    32'(flush3),    32'd1);
    chk("f3_c3_epc_we",   32'(epc_we3),   32'd0);
    tick();
    chk("f3_c4_flush",    32'(flush3),    32'd0);
    chk("f3_c4_cause_we", 32'(cause_we3), 32'd0);
    tick();
    chk("f3_c5_cause_we", 32'(cause_we3), 32'd0);

    // reset mid-DRAIN
    repeat (2) tick();
    valid_i = 1'b1; exc_vec_i = 7'b0001000; pc_i = 32'h80008000;
    tick();
    idle_inputs();
    tick();
    chk("drain_flush_pre", 32'(flush3), 32'd1);
    rst = 1'b1;
    #1;
    chk("drain_rst_flush",  32'(flush3), 32'd0);
    chk("drain_rst_new_pc", new_pc3,     32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_flush", 32'(flush3), 32'd0);
    valid_i = 1'b1; exc_vec_i = 7'b0001000; pc_i = 32'h80009000;
    tick();
    idle_inputs();
    chk("post_rst_event", 32'(flush3),    32'd1);
    chk("post_rst_epc",   epc_wdata3,     32'h80009000);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception/interrupt controller; the consumer of the CP0 register file outputs (status, cause, epc) and the source of the CP0 exception-side updates (EPC, Cause.ExcCode/BD, Status.EXL, BadVAddr).
- Sits beside the MEM stage.
- Decides whether the instruction in MEM traps or returns (eret), then drives the pipeline flush, the redirect PC and the one-shot CP0 update strobes.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- FLUSH_CYCLES, 1, cycles flush_o stays high per event (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  1  MEM-stage instruction is valid
- exc_vec_i  in  7  {eret, ades, bp, sys, ov, ri, adel}
- pc_i  in  32  MEM-stage instruction PC
- bad_addr_i  in  32  faulting address (fetch PC or data address)
- in_delay_slot_i  in  1  MEM instruction is in a branch delay slot
- status_i  in  32  CP0 Status
- cause_i  in  32  CP0 Cause
- epc_i  in  32  CP0 EPC
- wb_cp0_we_i  in  1  mtc0 in WB
- wb_cp0_waddr_i  in  5  its CP0 register address
- wb_cp0_wdata_i  in  32  its data
- flush_o  out  1  flush IF..MEM
- new_pc_o  out  32  redirect target, valid while flush_o=1
- epc_we_o  out  1  EPC write strobe
- epc_wdata_o  out  32  EPC value
- cause_we_o  out  1  Cause.ExcCode/BD write strobe
- exc_code_o  out  5  ExcCode
- bd_o  out  1  Cause.BD
- exl_set_o  out  1  set Status.EXL
- exl_clr_o  out  1  clear Status.EXL (eret)
- badvaddr_we_o  out  1  BadVAddr write strobe
- badvaddr_o  out  32  BadVAddr value

Behaviour:
Reset:
- All outputs 0; FSM in IDLE.

Forwarding:
- Effective Status = wb_cp0_wdata_i when wb_cp0_we_i and waddr==12, else status_i.
- Effective Cause = cause_i with bits[9:8] replaced by wdata[9:8] when waddr==13.
- Effective EPC = wdata when waddr==14.

Interrupt condition:
- Status.IE(bit0)=1, Status.EXL(bit1)=0, and (Cause[15:8] & Status[15:8]) != 0.

Priority, highest first:
- Int, adel, ri, ov, sys, bp, ades, eret.
- Only the winner is acted on.

ExcCode values:
- Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.

FSM states:
- IDLE: if valid_i and any event, latch the event and go to FLUSH at the next edge. All outputs below are registered, so they are valid 1 cycle after detection.
- FLUSH (1 cycle):
  - flush_o=1.
  - Trap: new_pc_o=EXC_VECTOR; cause_we_o=1; exl_set_o=1.
  - Trap with effective EXL=0: epc_we_o=1; epc_wdata_o = in_delay_slot ? pc-4 : pc; bd_o = in_delay_slot.
  - Trap with EXL already 1: no EPC/BD update (epc_we_o=0, bd_o=0). ExcCode is still written.
  - eret: new_pc_o = effective EPC; exl_clr_o=1; no other strobes.
  - Go to DRAIN if FLUSH_CYCLES>1, else IDLE.
- DRAIN: flush_o=1, new_pc_o held, all strobes 0. Down-counter runs FLUSH_CYCLES-1 cycles, then IDLE.

Boundary rules:
- Strobes are single-cycle pulses, never repeated per event.
- Events arriving during FLUSH/DRAIN are discarded; those instructions are being flushed.
- valid_i=0 masks everything, including interrupts; interrupts are taken only on a valid instruction.
- pc-4 wraps modulo 2^32.
- Reset mid-FLUSH/DRAIN: immediate return to IDLE with all outputs 0.

Optional Feature:
Macro: CP0_EXC_BADVADDR_EN
- Defined: on adel/ades, badvaddr_we_o=1 in FLUSH with badvaddr_o=bad_addr_i (registered at detection).
- Undefined: badvaddr_we_o tied 0, badvaddr_o tied 0, bad_addr_i unused.

Decomposition:
- Shared header (system_reg.v): ExcCode constants, CP0 register addresses (Status 12, Cause 13, EPC 14, BadVAddr 8), exc_vec_i bit indices, Status/Cause bit positions.
- One sub-module: cp0_exc_prio. Combinational priority encoder; inputs exc_vec_i, interrupt condition and valid_i; outputs hit, is_eret, exc_code.

Test Plan:
1. Syscall, not in delay slot: pc=0x80001000 -> next cycle flush_o=1, new_pc_o=0xBFC00380, epc_wdata_o=0x80001000, exc_code_o=8, bd_o=0, exl_set_o=1, all for 1 cycle.
2. Ov in delay slot: pc=0x80002004 -> epc_wdata_o=0x80002000, bd_o=1, exc_code_o=12.
3. Interrupts, using effective Status (forwarding check):
   - Status=0x0000FF01 from WB forwarding, cause_i[15:8]=0x04, valid_i=1 -> exc_code_o=0.
   - Same with forwarded Status.IE=0 -> no flush.
4. eret with epc_i=0x80003000 and a WB mtc0 writing EPC=0x80004000 -> new_pc_o=0x80004000, exl_clr_o=1, epc_we_o=0.
5. FLUSH_CYCLES=3, ri then a second sys on the next two cycles -> flush_o high 3 cycles, second event ignored, one strobe set only.
6. EXL=1 with bp -> cause_we_o=1, exc_code_o=9, epc_we_o=0. With CP0_EXC_BADVADDR_EN, adel with bad_addr_i=0x80000003 -> badvaddr_we_o=1, badvaddr_o=0x80000003. Reset asserted mid-DRAIN -> flush_o=0 immediately.
